// File: rtl/disp_scan.sv
// Four-digit multiplexed seven-segment scanner showing a frame-synchronous
// snapshot of the CPU accumulator (digits 0-1) and instruction pointer (digits 2-3).
module disp_scan #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned DEAD     = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] acc_v,
  input  logic [7:0] ip,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_tick_q, frame_tick_d;

  logic          wrap;
  logic          frame_end;
  logic [3:0]    nib;

  // Active-low glyphs, bit 6 = segment g down to bit 0 = segment a.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      4'hF: hex_glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    snap_d       = snap_q;
    an_d         = 4'b1111;
    seg_d        = 7'b1111111;
    dp_d         = 1'b1;
    nib          = snap_q[3:0];

    wrap         = (cnt_q == CW'(PRESCALE - 1));
    frame_end    = wrap && (idx_q == 2'd3);
    frame_tick_d = frame_end;

    if (wrap) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    if (frame_end) snap_d = {ip, acc_v};

    case (idx_q)
      2'd0: nib = snap_q[3:0];
      2'd1: nib = snap_q[7:4];
      2'd2: nib = snap_q[11:8];
      2'd3: nib = snap_q[15:12];
    endcase

    // Dead time at slot start keeps the previous digit from ghosting into this one.
    if (!blank && (cnt_q >= CW'(DEAD))) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex_glyph(nib);
      dp_d  = (idx_q != 2'd2);
    end
  end

  // NOTE: the snapshot is cleared on reset too, so a frame interrupted by reset
  // can never display stale data afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan at PRESCALE=8, DEAD=2: a cycle-indexed model
// pushes expected outputs per edge, each scenario task pops and compares them.
module tb_disp_scan;

  localparam int P = 8;
  localparam int D = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] acc_v;
  logic [7:0] ip;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  exp_t       sb[$];
  int         t;
  logic [15:0] snap_m;
  int         n_cmp;
  int         n_err;
  logic [6:0] glyph [16];

  disp_scan #(.PRESCALE(P), .DEAD(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .acc_v      (acc_v),
    .ip         (ip),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: before edge t+1 the counter holds t mod P and the slot (t/P) mod 4.
  task automatic advance();
    exp_t e;
    int   c;
    int   i;
    c    = t % P;
    i    = (t / P) % 4;
    e.an = (blank || c < D) ? 4'hF : ~(4'b0001 << i);
    e.seg = (e.an == 4'hF) ? 7'h7F : glyph[snap_m[4*i +: 4]];
    e.dp = (e.an != 4'hF && i == 2) ? 1'b0 : 1'b1;
    e.ft = (c == P - 1 && i == 3);
    sb.push_back(e);
    if (c == P - 1 && i == 3) snap_m = {ip, acc_v};
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic restart_model();
    t      = 0;
    snap_m = 16'h0000;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reset_hold: got an=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0", an, seg, dp, frame_tick);
      end
    end
    rst = 1'b1;
    restart_model();
  endtask

  task automatic test_first_frame();
    exp_t e;
    acc_v = 8'h3A;
    ip    = 8'h15;
    for (int k = 0; k < 32; k++) begin
      advance();
      e = sb.pop_front();
      n_cmp++;
      if ({an, seg, dp, frame_tick} !== e) begin
        n_err++;
        $display("FAIL first_frame t=%0d: got %b_%b_%b_%b want %b_%b_%b_%b", t, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.ft);
      end
      if (t == 3) begin
        n_cmp++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
          n_err++;
          $display("FAIL first_frame_zero: got an=%b seg=%b want an=1110 seg=1000000", an, seg);
        end
      end
    end
    n_cmp++;
    if (frame_tick !== 1'b1) begin
      n_err++;
      $display("FAIL first_tick_at_32: got %b want 1", frame_tick);
    end
  endtask

  task automatic test_display();
    exp_t       e;
    logic [3:0] an_w  [4];
    logic [6:0] seg_w [4];
    logic       dp_w  [4];
    int         k0;
    an_w  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_w = '{7'b0001000, 7'b0110000, 7'b0010010, 7'b1111001};
    dp_w  = '{1'b1, 1'b1, 1'b0, 1'b1};
    k0 = t;
    for (int k = 0; k < 32; k++) begin
      advance();
      e = sb.pop_front();
      n_cmp++;
      if ({an, seg, dp, frame_tick} !== e) begin
        n_err++;
        $display("FAIL display t=%0d: got %b_%b_%b_%b want %b_%b_%b_%b", t, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.ft);
      end
      if ((t - 1 - k0) % P == D) begin
        n_cmp++;
        if (an !== an_w[(t - 1 - k0) / P] || seg !== seg_w[(t - 1 - k0) / P] || dp !== dp_w[(t - 1 - k0) / P]) begin
          n_err++;
          $display("FAIL display_slot%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", (t - 1 - k0) / P,
                   an, seg, dp, an_w[(t - 1 - k0) / P], seg_w[(t - 1 - k0) / P], dp_w[(t - 1 - k0) / P]);
        end
      end
    end
  endtask

  task automatic test_hold_snapshot();
    exp_t e;
    int   k0;
    k0 = t;
    for (int k = 0; k < 64; k++) begin
      if (t == k0 + 12) acc_v = 8'hFF;
      advance();
      e = sb.pop_front();
      n_cmp++;
      if ({an, seg, dp, frame_tick} !== e) begin
        n_err++;
        $display("FAIL hold_snapshot t=%0d: got %b_%b_%b_%b want %b_%b_%b_%b", t, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.ft);
      end
      if (t == k0 + 15) begin
        n_cmp++;
        if (an !== 4'b1101 || seg !== 7'b0110000) begin
          n_err++;
          $display("FAIL hold_old_digit: got an=%b seg=%b want an=1101 seg=0110000", an, seg);
        end
      end
      if (t == k0 + 35 || t == k0 + 43) begin
        n_cmp++;
        if (seg !== 7'b0001110) begin
          n_err++;
          $display("FAIL hold_new_digit t=%0d: got seg=%b want seg=0001110", t, seg);
        end
      end
    end
  endtask

  task automatic test_dead_time_spacing();
    exp_t e;
    int   dead_n;
    int   last_tick;
    dead_n    = 0;
    last_tick = -1;
    for (int k = 0; k < 10 * 4 * P; k++) begin
      advance();
      e = sb.pop_front();
      n_cmp++;
      if ({an, seg, dp, frame_tick} !== e) begin
        n_err++;
        $display("FAIL dead_time t=%0d: got %b_%b_%b_%b want %b_%b_%b_%b", t, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.ft);
      end
      if (an === 4'hF) dead_n++;
      if ((t - 1) % P == P - 1) begin
        n_cmp++;
        if (dead_n != D) begin
          n_err++;
          $display("FAIL dead_count t=%0d: got %0d off cycles want %0d", t, dead_n, D);
        end
        dead_n = 0;
      end
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          n_cmp++;
          if (t - last_tick != 4 * P) begin
            n_err++;
            $display("FAIL tick_spacing: got %0d want %0d", t - last_tick, 4 * P);
          end
        end
        last_tick = t;
      end
    end
  endtask

  task automatic test_blank();
    exp_t e;
    int   k0;
    int   off_n;
    k0    = t;
    off_n = 0;
    acc_v = 8'h3A;
    for (int k = 0; k < 32; k++) begin
      blank = (t >= k0 + P + 3 && t < k0 + P + 8);
      advance();
      e = sb.pop_front();
      n_cmp++;
      if ({an, seg, dp, frame_tick} !== e) begin
        n_err++;
        $display("FAIL blank t=%0d: got %b_%b_%b_%b want %b_%b_%b_%b", t, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.ft);
      end
      if (t > k0 + P && t <= k0 + 2 * P && an === 4'hF) off_n++;
      if (t == k0 + P + 3) begin
        n_cmp++;
        if (an !== 4'b1101) begin
          n_err++;
          $display("FAIL blank_before: got an=%b want 1101", an);
        end
      end
    end
    blank = 1'b0;
    n_cmp++;
    if (off_n != D + 5) begin
      n_err++;
      $display("FAIL blank_off_count: got %0d want %0d", off_n, D + 5);
    end
    n_cmp++;
    if (frame_tick !== 1'b1) begin
      n_err++;
      $display("FAIL blank_tick: got %b want 1", frame_tick);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   k0;
    k0 = t;
    while (t < k0 + 2 * P + 5) begin
      advance();
      e = sb.pop_front();
      n_cmp++;
      if ({an, seg, dp, frame_tick} !== e) begin
        n_err++;
        $display("FAIL pre_reset t=%0d: got %b_%b_%b_%b want %b_%b_%b_%b", t, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.ft);
      end
    end
    n_cmp++;
    if (an !== 4'b1011 || seg !== 7'b0010010 || dp !== 1'b0) begin
      n_err++;
      $display("FAIL pre_reset_slot2: got an=%b seg=%b dp=%b want 1011 0010010 0", an, seg, dp);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got an=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0", an, seg, dp, frame_tick);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    restart_model();
    for (int k = 0; k < 40; k++) begin
      advance();
      e = sb.pop_front();
      n_cmp++;
      if ({an, seg, dp, frame_tick} !== e) begin
        n_err++;
        $display("FAIL post_reset t=%0d: got %b_%b_%b_%b want %b_%b_%b_%b", t, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.ft);
      end
      if (t == D + 1) begin
        n_cmp++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
          n_err++;
          $display("FAIL post_reset_zero: got an=%b seg=%b want 1110 1000000", an, seg);
        end
      end
      if (t == 4 * P) begin
        n_cmp++;
        if (frame_tick !== 1'b1) begin
          n_err++;
          $display("FAIL post_reset_tick: got %b want 1", frame_tick);
        end
      end
    end
  endtask

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b0;
    acc_v  = 8'h00;
    ip     = 8'h00;
    blank  = 1'b0;
    restart_model();

    test_reset();
    test_first_frame();
    test_display();
    test_hold_snapshot();
    test_dead_time_spacing();
    test_blank();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 The module SHALL have parameter PRESCALE, default 50000, meaning clock cycles per digit slot; legal values are 4 or more.
REQ-002 The module SHALL have parameter DEAD, default 2500, meaning anode-off cycles at the start of each slot; legal range is 1 to PRESCALE-2.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port acc_v, input, 8 bits: CPU accumulator value, synchronous to clk.
REQ-006 The module SHALL have port ip, input, 8 bits: CPU instruction pointer, synchronous to clk.
REQ-007 The module SHALL have port blank, input, 1 bit: 1 forces all digits off.
REQ-008 The module SHALL have port an, output, 4 bits: digit enables, active-low; an[k] drives digit k.
REQ-009 The module SHALL have port seg, output, 7 bits: segments, active-low; seg[0]=a through seg[6]=g.
REQ-010 The module SHALL have port dp, output, 1 bit: decimal point, active-low.
REQ-011 The module SHALL have port frame_tick, output, 1 bit: one-cycle pulse marking each snapshot capture.

Function
REQ-012 Counter cnt (0..PRESCALE-1) SHALL increment every cycle and wrap to 0 after PRESCALE-1; slot index idx (0..3) SHALL advance by 1, mod 4, on each cnt wrap.
REQ-013 A 16-bit snapshot register SHALL load {ip, acc_v} on the cycle where cnt wraps while idx==3; frame_tick SHALL be 1 for exactly the following cycle.
REQ-014 Displayed nibble SHALL come only from the snapshot: slot0 = acc_v[3:0], slot1 = acc_v[7:4], slot2 = ip[3:0], slot3 = ip[7:4]. Input changes between captures SHALL have no visible effect.
REQ-015 an, seg, dp and frame_tick SHALL be registered outputs; each SHALL reflect cnt/idx/snapshot/blank with exactly 1 cycle of latency.
REQ-016 While cnt < DEAD, an SHALL be 4'b1111. Otherwise an SHALL have only bit idx low.
REQ-017 seg SHALL encode the slot nibble as hex glyphs 0-9, A, b, C, d, E, F, active-low. Examples: 0=1000000, 1=1111001, 3=0110000, 5=0010010, A=0001000. seg SHALL be 1111111 whenever an==1111.
REQ-018 dp SHALL be 0 only while slot 2 is enabled, acting as the acc/ip separator; otherwise dp SHALL be 1.
REQ-019 blank=1 sampled on cycle N SHALL give an=1111, seg=1111111 and dp=1 from cycle N+1. cnt, idx, snapshot and frame_tick SHALL continue unaffected, and display SHALL resume at the current slot position when blank drops.
REQ-020 Frame period SHALL be exactly 4*PRESCALE cycles, with frame_tick spacing exactly 4*PRESCALE cycles.

Reset
REQ-021 With rst=0, asynchronously and regardless of clk, the block SHALL force: cnt=0, idx=0, snapshot=16'h0000, an=1111, seg=1111111, dp=1, frame_tick=0.
REQ-022 After rst rises, slot 0 SHALL begin on the first clk edge. The first frame SHALL display snapshot 0000, and the first frame_tick SHALL occur 4*PRESCALE cycles later.
REQ-023 Reset asserted mid-slot or mid-frame SHALL discard the partial frame; no stale snapshot SHALL survive.

Verification (PRESCALE=8, DEAD=2)
REQ-024 Hold rst=0 and toggle clk -> an=1111, seg=1111111, dp=1, frame_tick=0 throughout. Release rst -> first frame_tick 32 cycles later.
REQ-025 Hold acc_v=8'h3A and ip=8'h15; after frame_tick -> slot0 an=1110 seg=0001000; slot1 an=1101 seg=0110000; slot2 an=1011 seg=0010010 dp=0; slot3 an=0111 seg=1111001.
REQ-026 Change acc_v 3A->FF mid-frame -> digits stay 3A until the next frame_tick, then show FF (seg=0001110).
REQ-027 In every 8-cycle slot, check dead time -> an=1111 for 2 cycles, enabled for 6 cycles; frame_tick spacing is 32 cycles across 10 frames.
REQ-028 Pulse blank=1 for 5 cycles in slot 1 -> an=1111 for exactly 5 cycles, offset by 1 cycle; frame_tick timing unchanged.
REQ-029 Assert rst at cnt=5 of slot 2 with snapshot 3A15 -> outputs go to reset values immediately. After release -> slot 0 shows 0 (seg=1000000) and the frame_tick interval restarts.
